// File: rtl/fft_frame_streamer_pkg.sv
// Shared types and helpers for the FFT frame streamer: frame-size clamp and
// real-to-complex packing (real MSB-aligned, imaginary zero).
package fft_stream_pkg;

  localparam int MIN_LOG2 = 3;
  localparam int MAX_W    = 32;

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [3:0] clamp_log2(input logic [3:0] frame_size, input int max_log2);
    if (int'(frame_size) < MIN_LOG2) return 4'(MIN_LOG2);
    if (int'(frame_size) > max_log2) return 4'(max_log2);
    return frame_size;
  endfunction

  // Low 2*out_w bits of the result are {imag, real}; everything above is zero.
  function automatic logic [2*MAX_W-1:0] pack_complex(input logic [MAX_W-1:0] value,
                                                      input int in_w, input int out_w);
    logic [MAX_W-1:0] re;
    logic [MAX_W-1:0] mask;
    re   = value << (MAX_W - in_w);
    re   = $signed(re) >>> (MAX_W - out_w);
    mask = ~({MAX_W{1'b1}} << out_w);
    return {{MAX_W{1'b0}}, re & mask};
  endfunction

endpackage

// File: rtl/fft_frame_streamer_if.sv
// Sample input plus AXI-Stream-style complex output bundle; master is the
// streamer, slave is the sample source / FFT core side.
interface fft_frame_streamer_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]    value;
  logic               valueValid;
  logic [2*OUT_W-1:0] tData;
  logic               tValid;
  logic               tLast;
  logic               tReady;

  modport master (input value, valueValid, tReady, output tData, tValid, tLast);
  modport slave  (output value, valueValid, tReady, input tData, tValid, tLast);
endinterface

// File: rtl/fft_frame_streamer_sample_fifo.sv
// Synchronous FIFO with first-word-fall-through head register and occupancy count.
// A write into an empty FIFO shows on dout_o next cycle; caller never writes when full unless reading.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_i,
  input  logic [W-1:0]           din_i,
  input  logic                   rd_i,
  output logic [W-1:0]           dout_o,
  output logic                   vld_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic          load, mem_rd, bypass, mem_wr;

  // The head register is refilled from memory first; an empty memory lets the write go straight to the head.
  always_comb begin
    load       = !head_vld_q || rd_i;
    mem_rd     = load && (mem_cnt_q != '0);
    bypass     = load && (mem_cnt_q == '0) && wr_i;
    mem_wr     = wr_i && !bypass;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (mem_rd) begin
      head_d     = mem[rd_ptr_q];
      head_vld_d = 1'b1;
    end else if (bypass) begin
      head_d     = din_i;
      head_vld_d = 1'b1;
    end else if (load) begin
      head_vld_d = 1'b0;
    end
    wr_ptr_d  = wr_ptr_q + AW'(mem_wr);
    rd_ptr_d  = rd_ptr_q + AW'(mem_rd);
    mem_cnt_d = mem_cnt_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign dout_o  = head_q;
  assign vld_o   = head_vld_q;
  assign level_o = mem_cnt_q + (AW+1)'(head_vld_q);

endmodule

// File: rtl/fft_frame_streamer.sv
// Buffers real samples, packs them complex and streams FFT frames (tLast every 2^frameLog beats); 1-cycle latency,
// no input backpressure (drops set sticky overflow). FRAME_ALIGN_EN: a frame starts only once fully buffered.
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int DEPTH    = 1024,
  parameter int MAX_LOG2 = 10
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  fft_frame_streamer_if.master         bus,
  input  logic [3:0]                   frameSize,
  output logic                         overflow,
  input  logic                         overflowClr,
  output logic [$clog2(DEPTH):0]       level
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_t              state_q, state_d;
  logic [MAX_LOG2-1:0] beat_q, beat_d, last_idx;
  logic [3:0]          frame_log_q, frame_log_d, frame_log;
  logic                overflow_q, overflow_d;
  logic [IN_W-1:0]     head;
  logic                head_vld, start_ok, t_vld, t_last, pop, full, wr, drop;

  sample_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_i    (wr),
    .din_i   (bus.value),
    .rd_i    (pop),
    .dout_o  (head),
    .vld_o   (head_vld),
    .level_o (level)
  );

  always_comb begin
    frame_log = (state_q == IDLE) ? clamp_log2(frameSize, MAX_LOG2) : frame_log_q;
    last_idx  = ~({MAX_LOG2{1'b1}} << frame_log);
`ifdef FRAME_ALIGN_EN
    start_ok  = (state_q == STREAM) || (level >= (LW'(1) << frame_log));
`else
    start_ok  = 1'b1;
`endif
    t_vld  = head_vld && start_ok;
    t_last = t_vld && (beat_q == last_idx);
    pop    = t_vld && bus.tReady;
    full   = (level == LW'(DEPTH));
    wr     = bus.valueValid && (!full || pop);
    drop   = bus.valueValid && !wr;
  end

  // Frame length is captured on the first beat so a mid-frame frameSize change waits for the next frame.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_log_d = frame_log_q;
    if (pop) begin
      if (state_q == IDLE) frame_log_d = frame_log;
      if (t_last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d = STREAM;
        beat_d  = beat_q + MAX_LOG2'(1);
      end
    end
    overflow_d = drop ? 1'b1 : (overflowClr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      frame_log_q <= 4'(MIN_LOG2);
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_log_q <= frame_log_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.tValid = t_vld;
  assign bus.tLast  = t_last;
  assign bus.tData  = (2*OUT_W)'(pack_complex(MAX_W'(head), IN_W, OUT_W));
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer: directed frames, stalls, frame-size
// changes and clamping, overflow, and MSB-aligned packing on a 12-bit instance.
module tb_fft_frame_streamer;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        last;
    logic [31:0] dat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  frameSize = 4'd3;
  logic [3:0]  frameSize2 = 4'd3;
  logic        overflowClr = 1'b0;
  logic        overflowClr2 = 1'b0;
  logic        overflow, overflow2;
  logic [10:0] level;
  logic [4:0]  level2;
  logic        toggle_rdy = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          beats = 0;
  int          b0;
  int          n;
  exp_t        exp_q[$];
  logic [11:0] v12 [8];
  logic [31:0] e12 [8];

  always #5 CLK = ~CLK;

  fft_frame_streamer_if #(.IN_W(16), .OUT_W(16)) bus ();
  fft_frame_streamer_if #(.IN_W(12), .OUT_W(16)) bus2 ();

  fft_frame_streamer #(.IN_W(16), .OUT_W(16), .DEPTH(DEPTH), .MAX_LOG2(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .frameSize(frameSize),
    .overflow(overflow), .overflowClr(overflowClr), .level(level));

  fft_frame_streamer #(.IN_W(12), .OUT_W(16), .DEPTH(16), .MAX_LOG2(4)) dut12 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus2), .frameSize(frameSize2),
    .overflow(overflow2), .overflowClr(overflowClr2), .level(level2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (toggle_rdy) bus.tReady = ~bus.tReady;
  endtask

  task automatic send(input logic [15:0] v, input logic last);
    bus.value      = v;
    bus.valueValid = 1'b1;
    exp_q.push_back({last, 16'h0000, v});
    tick();
    bus.valueValid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    tick();
    tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic monitor();
    logic [31:0] pd;
    logic        pl;
    logic        pstall;
    exp_t        e;
    pstall = 1'b0;
    pd     = '0;
    pl     = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        pstall = 1'b0;
        continue;
      end
      if (pstall) begin
        chk("hold_tvalid", bus.tValid, 1);
        chk("hold_tdata", bus.tData, pd);
        chk("hold_tlast", bus.tLast, pl);
      end
      if (bus.tValid && bus.tReady) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0h expected=no beat", bus.tData);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", bus.tData, e.dat);
          chk("beat_tlast", bus.tLast, e.last);
        end
      end
      pstall = bus.tValid && !bus.tReady;
      pd     = bus.tData;
      pl     = bus.tLast;
    end
  endtask

  initial begin
    bus.value       = '0;
    bus.valueValid  = 1'b0;
    bus.tReady      = 1'b0;
    bus2.value      = '0;
    bus2.valueValid = 1'b0;
    bus2.tReady     = 1'b0;
    v12 = '{12'h800, 12'h7FF, 12'h001, 12'hFFF, 12'h000, 12'h123, 12'h400, 12'hC00};
    e12 = '{32'h8000, 32'h7FF0, 32'h0010, 32'hFFF0, 32'h0000, 32'h1230, 32'h4000, 32'hC000};
    fork
      monitor();
    join_none

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tvalid", bus.tValid, 0);
    chk("rst_tlast", bus.tLast, 0);
    chk("rst_tdata", bus.tData, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);
    RST_N = 1'b1;
    tick();

    // Basic 8-beat frame
    frameSize  = 4'd3;
    bus.tReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), i == 8);
`ifndef FRAME_ALIGN_EN
      if (i == 1) chk("first_latency_tvalid", bus.tValid, 1);
`endif
    end
    drain("frame8_drain", 40);
    chk("frame8_level", level, 0);

    // tReady toggling every cycle during a 16-beat frame
    frameSize  = 4'd4;
    b0         = beats;
    toggle_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send(16'(16'h0100 + i), i == 15);
    drain("toggle_drain", 80);
    toggle_rdy = 1'b0;
    bus.tReady = 1'b1;
    chk("toggle_beats", beats - b0, 16);

    // frameSize 3 -> 5 after the 2nd beat of a frame
    frameSize  = 4'd3;
    bus.tReady = 1'b0;
    b0         = beats;
    for (int i = 0; i < 8; i++) send(16'(16'h0200 + i), i == 7);
    bus.tReady = 1'b1;
    n = 0;
    while (beats < b0 + 2 && n < 20) begin
      tick();
      n++;
    end
    chk("fs_change_at_beat2", beats - b0, 2);
    frameSize = 4'd5;
    for (int i = 0; i < 32; i++) send(16'(16'h0300 + i), i == 31);
    drain("fs_change_drain", 120);
    chk("fs_change_beats", beats - b0, 40);

    // frameSize=1 clamps to 8-beat frames
    frameSize = 4'd1;
    for (int i = 0; i < 16; i++) send(16'(16'h0400 + i), i == 7 || i == 15);
    drain("clamp_min_drain", 60);

    // Fill to DEPTH with tReady low, drops, overflow set/clear, then a clamped 1024-beat frame
    frameSize  = 4'd15;
    bus.tReady = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) begin
        send(16'(i), i == DEPTH - 1);
      end else begin
        bus.value      = 16'hDEAD;
        bus.valueValid = 1'b1;
        tick();
        bus.valueValid = 1'b0;
      end
      if (i == DEPTH - 1) begin
        chk("full_level", level, DEPTH);
        chk("full_no_overflow", overflow, 0);
      end
      if (i == DEPTH) chk("first_drop_overflow", overflow, 1);
    end
    bus.value      = 16'hBEEF;
    bus.valueValid = 1'b1;
    overflowClr    = 1'b1;
    tick();
    chk("clr_vs_drop_overflow", overflow, 1);
    bus.valueValid = 1'b0;
    tick();
    chk("clr_alone_overflow", overflow, 0);
    overflowClr = 1'b0;
    chk("full_level_hold", level, DEPTH);
    bus.tReady = 1'b1;
    drain("frame1024_drain", DEPTH + 40);
    chk("frame1024_level", level, 0);

`ifdef FRAME_ALIGN_EN
    // A frame only starts once 2^frameLog samples are buffered
    frameSize = 4'd4;
    for (int i = 0; i < 15; i++) begin
      send(16'(16'h0500 + i), 1'b0);
      chk("align_hold_tvalid", bus.tValid, 0);
    end
    send(16'h050F, 1'b1);
    chk("align_start_tvalid", bus.tValid, 1);
    drain("align_drain", 40);
`endif

    // 12-bit samples MSB-aligned into 16-bit real field, imag zero
    for (int i = 0; i < 8; i++) begin
      bus2.value      = v12[i];
      bus2.valueValid = 1'b1;
      tick();
    end
    bus2.valueValid = 1'b0;
    tick();
    chk("pack12_level", level2, 8);
    bus2.tReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pack12_tvalid", bus2.tValid, 1);
      chk("pack12_tdata", bus2.tData, e12[i]);
      tick();
    end
    chk("pack12_empty_tvalid", bus2.tValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Parametrised successor of the FFT input handler. Accepts real-valued time-domain samples (no backpressure, ADC style), buffers them in an internal FIFO, and packs them into complex words.
- Streams the words to the FFT core over an AXI-Stream-style tData/tValid/tReady/tLast interface, with tLast marking every 2^frameSize-th beat.
- Sits between the audio sample source and the FFT core.

Parameters:
- IN_W, 16, input sample width (bits).
- OUT_W, 16, width of each of the real and imaginary output fields; OUT_W >= IN_W is required.
- DEPTH, 1024, FIFO depth in samples; must be a power of two.
- MAX_LOG2, 10, largest transform size exponent accepted; must satisfy 2^MAX_LOG2 <= DEPTH.

Ports:
- CLK  in  1  system clock, all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- value  in  IN_W  signed real sample.
- valueValid  in  1  value is valid this cycle.
- frameSize  in  4  transform size exponent; N = 2^frameSize.
- tData  out  2*OUT_W  complex sample: {imag[2*OUT_W-1:OUT_W], real[OUT_W-1:0]}.
- tValid  out  1  tData is valid.
- tLast  out  1  beat is the last of a frame.
- tReady  in  1  FFT can accept data.
- overflow  out  1  sticky flag: a sample was dropped.
- overflowClr  in  1  clears overflow.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert use): tValid=0, tLast=0, tData=0, overflow=0, level=0. FIFO empty, beat counter 0, state IDLE.
- Reset mid-frame aborts the frame; the FFT must be re-synced by the system.
- Write: a sample is stored when valueValid=1 and (level<DEPTH or a read occurs in the same cycle).
- Drop: otherwise, with valueValid=1, the sample is dropped and overflow sets.
- Overflow set vs clear: if overflowClr and a new drop coincide, set wins.
- Packing:
  - real = value sign-extended to IN_W, then shifted left by (OUT_W-IN_W), i.e. MSB-aligned with zero LSBs.
  - imag = 0.
- Output register: first-word-fall-through.
  - tValid=1 whenever a head word is presented.
  - tData and tLast are held stable while tValid=1 and tReady=0.
  - A beat transfers on tValid&&tReady; the next word appears the following cycle if available, allowing one beat per cycle sustained.
- Latency: sample written in cycle k with FIFO empty gives tValid=1 in cycle k+1.
- Frame length: frameLog = clamp(frameSize, 3, MAX_LOG2).
  - frameLog is latched on the first beat transfer of each frame.
  - While in IDLE, the live frameSize is used for tLast evaluation.
  - A frameSize change mid-frame has no effect until the next frame.
- State machine:
  - IDLE (beat count 0) -> STREAM on first transfer.
  - STREAM -> IDLE on the transfer with tLast=1.
  - tLast=1 exactly when the presented beat has index 2^frameLog-1.
- level: updated each cycle as +write -read; simultaneous write and read leaves level unchanged.
- Wrap-around: FIFO pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from level.
- Dropped samples do not alter the beat counter; frame alignment against the source is the system's concern, reported via overflow.

Optional Feature:
- Macro: FRAME_ALIGN_EN.
- Defined: a frame starts (IDLE -> tValid=1) only when level >= 2^frameLog, so a frame is never starved mid-frame. Inside STREAM, beats flow as available.
- Not defined: tValid follows FIFO non-empty at all times.

Decomposition:
- Package fft_stream_pkg holds:
  - constant MIN_LOG2=3;
  - function clamp_log2(frameSize, MAX_LOG2);
  - function pack_complex(value) implementing the MSB-align and zero-imag rule;
  - state enum {IDLE, STREAM}.
- One sub-module: sample_fifo, a parametrised (width, DEPTH) synchronous FIFO with FWFT output register and level output.
- The frame counter/FSM and overflow logic stay in the top module.

Test Plan:
- Reset then 8 samples 1..8, frameSize=3, tReady=1 -> 8 beats, tData real=1..8, imag=0, tLast only on the 8th, level returns to 0.
- IN_W=12, OUT_W=16, value=12'h800 -> tData[15:0]=16'h8000, tData[31:16]=0.
- tReady toggled 1/0 every cycle during a 16-sample frame (frameSize=4) -> tData/tLast held stable on stalls, exactly 16 beats, tLast on the 16th.
- tReady=0 while DEPTH+3 samples are written -> level=DEPTH, overflow=1 after the first extra sample. overflowClr with a simultaneous drop -> overflow stays 1. overflowClr alone -> overflow 0.
- frameSize changed 3 -> 5 after the 2nd beat of a frame -> tLast still on beat 8, next frame tLast on beat 32. frameSize=15 clamps to MAX_LOG2 (tLast on beat 1024). frameSize=1 clamps to 3.
- With FRAME_ALIGN_EN, frameSize=4, 15 samples written -> tValid stays 0; 16th sample -> tValid=1 next cycle.
